// File: rtl/reg32_byte_reader_pkg.sv
// Shared types, sizes and the byte-lane extract helper for the 32-bit byte reader.
package reg32_byte_reader_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                  input logic [LANE_W-1:0] lane);
    return BYTE_W'(word >> {lane, 3'b000});
  endfunction

endpackage

// File: rtl/reg32_byte_reader_lane_pick.sv
// Combinational priority encoder: picks the next lane to emit from a pending-lane mask.
module reg32_byte_reader_lane_pick
  import reg32_byte_reader_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [LANES-1:0]  mask,
  output logic [LANE_W-1:0] lane,
  output logic              any,
  output logic              only
);

  always_comb begin
    lane = '0;
    // Later iterations win, so scan order sets the priority direction.
    if (LSB_FIRST) begin
      for (int i = int'(LANES) - 1; i >= 0; i--) begin
        if (mask[i]) lane = LANE_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (mask[i]) lane = LANE_W'(i);
      end
    end
    any  = |mask;
    only = any && ((mask & (mask - LANES'(1))) == '0);
  end

endmodule

// File: rtl/reg32_byte_reader.sv
// Takes a 32-bit word plus byte-enable mask and streams the enabled lanes out one byte per cycle.
module reg32_byte_reader
  import reg32_byte_reader_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LANES-1:0]  in_be,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_last,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [LANES-1:0]    rem_q, rem_d;

  logic [LANE_W-1:0]   pick_lane;
  logic                pick_any;
  logic                pick_only;
  logic                out_fire;
  logic                in_fire;

  reg32_byte_reader_lane_pick #(
    .LSB_FIRST (LSB_FIRST)
  ) u_lane_pick (
    .mask (rem_q),
    .lane (pick_lane),
    .any  (pick_any),
    .only (pick_only)
  );

  // Output/handshake decode and next-state logic.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    rem_d     = rem_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_lane  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    in_ready  = 1'b0;

    if (!reset && state_q == SEND && pick_any) begin
      out_valid = 1'b1;
      out_data  = lane_byte(word_q, pick_lane);
      out_lane  = pick_lane;
      out_last  = pick_only;
    end
    busy     = !reset && (state_q == SEND);
    out_fire = out_valid && out_ready;
    in_ready = !reset && ((state_q == IDLE) || (out_fire && out_last));
    in_fire  = in_valid && in_ready;

    if (out_fire) begin
      rem_d = rem_q & ~(LANES'(1) << pick_lane);
      if (pick_only) state_d = IDLE;
    end
    // A word accepted alongside the last byte overrides the drain to IDLE.
    if (in_fire) begin
      if (in_be != '0) begin
        word_d  = in_data;
        rem_d   = in_be;
        state_d = SEND;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_reg32_byte_reader.sv
// Randomized plus directed bench for reg32_byte_reader; both lane orders run side by side against a queue model.
module tb_reg32_byte_reader;

  typedef struct {
    logic [7:0] d;
    logic [1:0] l;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_be = '0;
  logic        out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [7:0] a_out_data;
  logic [1:0] a_out_lane;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [7:0] b_out_data;
  logic [1:0] b_out_lane;

  reg32_byte_reader #(.LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_be(in_be), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_lane(a_out_lane), .out_last(a_out_last), .busy(a_busy)
  );

  reg32_byte_reader #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_be(in_be), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_lane(b_out_lane), .out_last(b_out_last), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   last_accept;
  int   bytes_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model, then advance the model across the coming edge.
  task automatic check_cycle();
    bit   ev, eir;
    exp_t e;
    ev  = !reset && (q_a.size() != 0);
    eir = !reset && ((q_a.size() == 0) || (q_a.size() == 1 && out_ready));
    check_eq("in_ready_lsb", 32'(a_in_ready), 32'(eir));
    check_eq("in_ready_msb", 32'(b_in_ready), 32'(eir));
    check_eq("out_valid_lsb", 32'(a_out_valid), 32'(ev));
    check_eq("out_valid_msb", 32'(b_out_valid), 32'(ev));
    check_eq("busy_lsb", 32'(a_busy), 32'(ev));
    check_eq("busy_msb", 32'(b_busy), 32'(ev));
    if (ev) begin
      e = q_a[0];
      check_eq("data_lsb", 32'(a_out_data), 32'(e.d));
      check_eq("lane_lsb", 32'(a_out_lane), 32'(e.l));
      check_eq("last_lsb", 32'(a_out_last), 32'(e.last));
      e = q_b[0];
      check_eq("data_msb", 32'(b_out_data), 32'(e.d));
      check_eq("lane_msb", 32'(b_out_lane), 32'(e.l));
      check_eq("last_msb", 32'(b_out_last), 32'(e.last));
    end else begin
      check_eq("idle_outs_lsb", {21'd0, a_out_data, a_out_lane, a_out_last}, 32'd0);
      check_eq("idle_outs_msb", {21'd0, b_out_data, b_out_lane, b_out_last}, 32'd0);
    end

    last_accept = 1'b0;
    if (reset) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (ev && out_ready) begin
        void'(q_a.pop_front());
        void'(q_b.pop_front());
        bytes_seen++;
      end
      if (in_valid && eir) begin
        last_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
          if (in_be[k]) q_a.push_back('{8'(in_data >> (8 * k)), 2'(k), ((in_be >> (k + 1)) == 4'd0)});
        end
        for (int k = 3; k >= 0; k--) begin
          if (in_be[k]) q_b.push_back('{8'(in_data >> (8 * k)), 2'(k), ((in_be & 4'((1 << k) - 1)) == 4'd0)});
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] be,
                      input logic ordy, input logic rst);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_be     = be;
    out_ready = ordy;
    reset     = rst;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] be);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step(1'b1, d, be, 1'b1, 1'b0);
      done = last_accept;
    end
    if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
  endtask

  logic [6:0] bp_pat;

  initial begin
    bytes_seen = 0;
    step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
    drain(2);

    // Full word, then sparse mask with an exact byte count.
    send_word(32'hA1B2C3D4, 4'hF);
    drain(5);
    bytes_seen = 0;
    send_word(32'h11223344, 4'b0101);
    drain(4);
    check_eq("sparse_count", 32'(bytes_seen), 32'd2);

    // Backpressure with out_ready 1,0,0,1,1,0,1.
    bp_pat = 7'b1011001;
    bytes_seen = 0;
    send_word(32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 4'd0, bp_pat[i], 1'b0);
    drain(3);
    check_eq("bp_count", 32'(bytes_seen), 32'd4);

    // Zero enable, then back-to-back full words.
    bytes_seen = 0;
    send_word(32'h55555555, 4'h0);
    send_word(32'h01020304, 4'hF);
    send_word(32'h05060708, 4'hF);
    drain(6);
    check_eq("b2b_count", 32'(bytes_seen), 32'd8);

    // Reset after the second byte handshake.
    send_word(32'hCAFEF00D, 4'hF);
    step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);
    bytes_seen = 0;
    send_word(32'h000000AA, 4'h1);
    drain(3);
    check_eq("single_count", 32'(bytes_seen), 32'd1);

    // Random traffic with occasional zero masks and resets.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end
    drain(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg32_byte_reader.md
Name: reg32_byte_reader

Overview:
- Read-side counterpart to the byte-laned 32-bit register store.
- Accepts one 32-bit word plus a 4-bit byte-enable mask over a valid/ready handshake.
- Streams out only the enabled byte lanes, one byte per cycle, over a second valid/ready handshake.
- Feeds the DMAC byte path from ALU/register-bank words; tags each byte with its lane index and marks the last byte of each word.

Parameters:
- LSB_FIRST, 1: 1 = emit enabled lanes in ascending order (lane 0 = bits 7:0 first); 0 = descending order.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  reset is synchronous and active-high.
- in_valid  in  1  word offered.
- in_ready  out  1  block can take a word this cycle.
- in_data  in  32  word; lane k = bits 8k+7:8k.
- in_be  in  4  byte enables; bit k selects lane k.
- out_valid  out  1  byte presented.
- out_ready  in  1  consumer takes the byte this cycle.
- out_data  out  8  byte value.
- out_lane  out  2  lane index of out_data.
- out_last  out  1  final enabled byte of the current word.
- busy  out  1  a word is held (state SEND).

Behaviour:
- State: IDLE or SEND. word_q[31:0] holds the word; rem_q[3:0] holds lanes still to emit.
- Reset (synchronous, highest priority): state IDLE, word_q 0, rem_q 0, busy 0. While reset is high, in_ready 0 and out_valid 0.
- Outputs in reset or IDLE: out_valid 0, out_data 0, out_lane 0, out_last 0.
- Current lane selection:
  - LSB_FIRST=1: lowest set bit of rem_q.
  - LSB_FIRST=0: highest set bit of rem_q.
- SEND outputs:
  - out_valid 1.
  - out_data = word_q byte at the current lane.
  - out_lane = current lane.
  - out_last = 1 when rem_q has exactly one bit set.
- Outputs depend only on registered state; there is no combinational path from in_* to out_*.
- Output hold: while out_valid is high and out_ready is low, out_data, out_lane and out_last stay stable.
- in_ready = (state==IDLE) OR (state==SEND AND out_valid AND out_ready AND out_last), gated low by reset.
- Input accept (in_valid AND in_ready):
  - in_be != 0: load word_q and rem_q = in_be; state becomes SEND.
  - in_be == 0: word is consumed and discarded; no byte emitted; state stays or becomes IDLE.
- Byte handshake (out_valid AND out_ready): clear the current lane bit in rem_q.
  - If it was the last lane and no simultaneous accept: go to IDLE.
  - If a simultaneous accept occurs: the new word's load wins and state stays SEND.
- Latency: a word accepted at edge N presents its first byte in the cycle after edge N. It is never presented in the accept cycle itself.
- Throughput:
  - With out_ready held high, one byte per cycle.
  - Back-to-back words produce no bubble between the last byte of word k and the first byte of word k+1.
  - Per word: popcount(in_be) cycles.
- Reset mid-word: pending bytes are dropped; no out_valid in the cycle after reset deasserts; next accept starts fresh.
- Word with a single enable bit: one byte, with out_last 1.

Decomposition:
- Shared package:
  - LANES = 4 and LANE_W = 2.
  - State type {IDLE, SEND}.
  - Byte-lane extract function (word, lane) returning 8 bits.
- One sub-module, lane_pick:
  - Inputs: 4-bit mask, LSB_FIRST.
  - Outputs: lane index, any (mask != 0), only (exactly one bit set).
  - Purely combinational priority encoder, instanced once on rem_q.

Test Plan:
- Full word: in_data 0xA1B2C3D4, in_be 0xF, out_ready 1 → bytes D4,C3,B2,A1 on lanes 0,1,2,3 in the 4 cycles after accept; out_last only on A1; in_ready 0 for the first 3 of those cycles.
- Sparse mask: 0x11223344, in_be 0b0101 → 44 lane 0, then 22 lane 2 with out_last 1; exactly 2 byte cycles.
- Backpressure: 0xDEADBEEF, in_be 0xF, out_ready toggling 1,0,0,1,1,0,1 → EF,BE,AD,DE delivered in order; out_data/out_lane held during stalled cycles; no loss or duplication.
- Zero enable and back-to-back:
  - Word 0x55555555 with in_be 0 → accepted, no out_valid.
  - Immediately after, 0x01020304 and 0x05060708 both in_be 0xF with out_ready 1 → 8 consecutive bytes 04,03,02,01,08,07,06,05 with no gap.
- Reset mid-word: 0xCAFEF00D, in_be 0xF; reset high for one cycle after the second byte handshake → out_valid 0 in the following cycle; next word 0x000000AA, in_be 0x1 → single byte AA, lane 0, out_last 1.
- LSB_FIRST=0: 0xA1B2C3D4, in_be 0b1011 → A1 lane 3, C3 lane 1, D4 lane 0 with out_last 1.
